// File: rtl/vga_plot_sink.sv
// Plot-interface sink: captures vga_plot strobes into a colour framebuffer with
// saturating plot/out-of-bounds/drop counters, a zero-fill clear sweep and a pixel readback port.
module vga_plot_sink #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                clear_req,
    output logic                busy,
    input  logic                rd_req,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic [15:0]         plot_count,
    output logic [15:0]         oob_count,
    output logic [15:0]         drop_count
);

    localparam int          NPIX      = WIDTH * HEIGHT;
    localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
    localparam int          CNT_PLOT  = 0;
    localparam int          CNT_OOB   = 1;
    localparam int          CNT_DROP  = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;

    logic                plot_in_range;
    logic                rd_in_range;
    logic [14:0]         plot_addr;
    logic [14:0]         rd_addr;

    logic                mem_we;
    logic [14:0]         mem_waddr;
    logic [COLOUR_W-1:0] mem_wdata;
    logic                rd_fire;
    logic                cnt_clr;
    logic [2:0]          cnt_inc;
    logic [47:0]         cnt_all;

    logic [COLOUR_W-1:0] mem [0:NPIX-1];
    logic [COLOUR_W-1:0] rd_data_q;
    logic                rd_fire_q;
    logic                rd_oob_q;
    logic                rd_valid_q;
    logic [COLOUR_W-1:0] rd_colour_q;

    // Coordinates are range-checked before addressing; never wrapped into the buffer.
    assign plot_in_range = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    assign rd_in_range   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign plot_addr     = 15'(32'(vga_y) * WIDTH + 32'(vga_x));
    assign rd_addr       = 15'(32'(rd_y) * WIDTH + 32'(rd_x));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = plot_addr;
        mem_wdata  = vga_colour;
        rd_fire    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = '0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    // Entering CLEAR swallows any same-cycle plot or read.
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    cnt_clr    = 1'b1;
                end else begin
                    rd_fire = rd_req;
                    if (vga_plot) begin
                        if (plot_in_range) begin
                            mem_we            = 1'b1;
                            cnt_inc[CNT_PLOT] = 1'b1;
                        end else begin
                            cnt_inc[CNT_OOB] = 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
                if (vga_plot) begin
                    if (plot_in_range) begin
                        cnt_inc[CNT_DROP] = 1'b1;
                    end else begin
                        cnt_inc[CNT_OOB] = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Framebuffer is left uninitialised so it maps onto block RAM; reads are read-first.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_fire) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_fire_q   <= 1'b0;
            rd_oob_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_colour_q <= '0;
        end else begin
            rd_fire_q  <= rd_fire;
            rd_oob_q   <= !rd_in_range;
            rd_valid_q <= rd_fire_q;
            if (rd_fire_q) begin
                rd_colour_q <= rd_oob_q ? '0 : rd_data_q;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [15:0] count_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count_q <= '0;
            end else if (cnt_clr) begin
                count_q <= '0;
            end else if (cnt_inc[gi] && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
        assign cnt_all[gi*16 +: 16] = count_q;
    end

    assign busy       = (state_q == ST_CLEAR);
    assign rd_valid   = rd_valid_q;
    assign rd_colour  = rd_colour_q;
    assign plot_count = cnt_all[CNT_PLOT*16 +: 16];
    assign oob_count  = cnt_all[CNT_OOB*16 +: 16];
    assign drop_count = cnt_all[CNT_DROP*16 +: 16];

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: clear sweep, table-driven plot/readback vectors,
// reset during a sweep and counter saturation.
module tb_vga_plot_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_req;
    logic        busy;
    logic        rd_req;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_valid;
    logic [2:0]  rd_colour;
    logic [15:0] plot_count;
    logic [15:0] oob_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    vga_plot_sink #(.WIDTH(160), .HEIGHT(120), .COLOUR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .clear_req  (clear_req),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .plot_count (plot_count),
        .oob_count  (oob_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Each row is one clock edge; expectations describe the outputs just after that edge.
    typedef struct {
        logic        plot;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  col;
        logic        rd;
        logic [7:0]  rx;
        logic [6:0]  ry;
        logic        exp_valid;
        logic [2:0]  exp_col;
        logic [15:0] exp_plot;
        logic [15:0] exp_oob;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic p, input int x, input int y, input int c,
                                input logic r, input int rx_v, input int ry_v,
                                input logic ev, input int ec,
                                input int ep, input int eo, input int ed);
        vec_t v;
        v.plot      = p;
        v.x         = 8'(x);
        v.y         = 7'(y);
        v.col       = 3'(c);
        v.rd        = r;
        v.rx        = 8'(rx_v);
        v.ry        = 7'(ry_v);
        v.exp_valid = ev;
        v.exp_col   = 3'(ec);
        v.exp_plot  = 16'(ep);
        v.exp_oob   = 16'(eo);
        v.exp_drop  = 16'(ed);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        clear_req  = 1'b0;
        rd_req     = 1'b0;
        rd_x       = '0;
        rd_y       = '0;
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        vga_plot   = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
    endtask

    task automatic set_read(input int x, input int y);
        rd_req = 1'b1;
        rd_x   = 8'(x);
        rd_y   = 7'(y);
    endtask

    initial begin
        int   cnt;
        logic any_valid;

        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_colour", 32'(rd_colour), 32'd0);
        check("reset_plot_count", 32'(plot_count), 32'd0);
        check("reset_oob_count", 32'(oob_count), 32'd0);
        check("reset_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full clear; a read on the entry edge and reads mid-sweep must not produce rd_valid
        clear_req = 1'b1;
        set_read(0, 0);
        tick();
        idle_inputs();
        check("clear_busy_rise", 32'(busy), 32'd1);
        cnt       = 0;
        any_valid = rd_valid;
        while (busy && cnt < 20000) begin
            cnt++;
            idle_inputs();
            case (cnt)
                1000, 5000, 9000, 15000: set_plot(5, 5, 7);
                2000:  set_plot(200, 5, 7);
                3000:  set_read(0, 0);
                7000:  clear_req = 1'b1;
                19200: set_plot(5, 5, 7);
                default: ;
            endcase
            tick();
            any_valid = any_valid | rd_valid;
        end
        $display("clear sweep: busy for %0d cycles", cnt);
        check("clear_busy_cycles", 32'(cnt), 32'd19200);
        check("clear_no_rd_valid", 32'(any_valid), 32'd0);
        check("clear_drop_count", 32'(drop_count), 32'd5);
        check("clear_oob_count", 32'(oob_count), 32'd1);
        check("clear_plot_count", 32'(plot_count), 32'd0);

        //           plot x   y   c   rd rx   ry   ev ec plot oob drop
        vecs[0]  = mk(1, 10, 20, 5,  0, 0,   0,   0, 0, 1, 1, 5);
        vecs[1]  = mk(1, 95, 1,  6,  1, 10,  20,  0, 0, 2, 1, 5);
        vecs[2]  = mk(0, 0,  0,  0,  1, 0,   0,   1, 5, 2, 1, 5);
        vecs[3]  = mk(0, 0,  0,  0,  1, 159, 119, 1, 0, 2, 1, 5);
        vecs[4]  = mk(0, 0,  0,  0,  1, 80,  60,  1, 0, 2, 1, 5);
        vecs[5]  = mk(1, 160, 0, 7,  0, 0,   0,   1, 0, 2, 2, 5);
        vecs[6]  = mk(1, 0, 120, 7,  0, 0,   0,   0, 0, 2, 3, 5);
        vecs[7]  = mk(1, 255, 127, 7, 1, 0,  1,   0, 0, 2, 4, 5);
        vecs[8]  = mk(0, 0,  0,  0,  1, 0,   0,   1, 0, 2, 4, 5);
        vecs[9]  = mk(0, 0,  0,  0,  1, 159, 119, 1, 0, 2, 4, 5);
        vecs[10] = mk(1, 7,  7,  1,  0, 0,   0,   1, 0, 3, 4, 5);
        vecs[11] = mk(1, 7,  7,  2,  1, 7,   7,   0, 0, 4, 4, 5);
        vecs[12] = mk(0, 0,  0,  0,  1, 7,   7,   1, 1, 4, 4, 5);
        vecs[13] = mk(0, 0,  0,  0,  1, 255, 0,   1, 2, 4, 4, 5);
        vecs[14] = mk(0, 0,  0,  0,  1, 95,  1,   1, 0, 4, 4, 5);
        vecs[15] = mk(0, 0,  0,  0,  1, 5,   5,   1, 6, 4, 4, 5);
        vecs[16] = mk(0, 0,  0,  0,  0, 0,   0,   1, 0, 4, 4, 5);
        vecs[17] = mk(0, 0,  0,  0,  0, 0,   0,   0, 0, 4, 4, 5);

        for (int i = 0; i < 18; i++) begin
            idle_inputs();
            if (vecs[i].plot) set_plot(int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].col));
            if (vecs[i].rd)   set_read(int'(vecs[i].rx), int'(vecs[i].ry));
            tick();
            $display("vec %0d: plot=%0b (%0d,%0d) c=%0d rd=%0b (%0d,%0d) -> valid=%0b col=%0d cnt=%0d/%0d/%0d",
                     i, vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].col,
                     vecs[i].rd, vecs[i].rx, vecs[i].ry,
                     rd_valid, rd_colour, plot_count, oob_count, drop_count);
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_rd_colour", i), 32'(rd_colour), 32'(vecs[i].exp_col));
            check($sformatf("vec%0d_plot_count", i), 32'(plot_count), 32'(vecs[i].exp_plot));
            check($sformatf("vec%0d_oob_count", i), 32'(oob_count), 32'(vecs[i].exp_oob));
            check($sformatf("vec%0d_drop_count", i), 32'(drop_count), 32'(vecs[i].exp_drop));
        end

        // Reset 100 cycles into a sweep: low addresses cleared, the rest retained
        idle_inputs();
        set_plot(1, 0, 3);
        tick();
        idle_inputs();
        clear_req = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 100; i++) begin
            idle_inputs();
            if (i == 10) set_plot(5, 5, 1);
            if (i == 20) set_plot(200, 0, 1);
            tick();
        end
        idle_inputs();
        check("midclear_busy_before_reset", 32'(busy), 32'd1);
        check("midclear_drop_before_reset", 32'(drop_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midclear_busy_after_reset", 32'(busy), 32'd0);
        check("midclear_plot_count", 32'(plot_count), 32'd0);
        check("midclear_oob_count", 32'(oob_count), 32'd0);
        check("midclear_drop_count", 32'(drop_count), 32'd0);
        check("midclear_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        set_read(1, 0);
        tick();
        set_read(10, 20);
        tick();
        check("abort_rd_valid_a", 32'(rd_valid), 32'd1);
        check("abort_cleared_pixel", 32'(rd_colour), 32'd0);
        set_read(7, 7);
        tick();
        check("abort_rd_valid_b", 32'(rd_valid), 32'd1);
        check("abort_kept_pixel_a", 32'(rd_colour), 32'd5);
        idle_inputs();
        tick();
        check("abort_rd_valid_c", 32'(rd_valid), 32'd1);
        check("abort_kept_pixel_b", 32'(rd_colour), 32'd2);
        check("abort_busy_stays_low", 32'(busy), 32'd0);

        // Saturation of plot_count
        set_plot(3, 3, 4);
        repeat (65534) tick();
        check("sat_plot_fffe", 32'(plot_count), 32'h0000FFFE);
        tick();
        check("sat_plot_ffff", 32'(plot_count), 32'h0000FFFF);
        repeat (5) tick();
        idle_inputs();
        check("sat_plot_hold", 32'(plot_count), 32'h0000FFFF);
        check("sat_oob_zero", 32'(oob_count), 32'd0);
        $display("saturation: plot_count=%0h after 65540 plots", plot_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
